// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, size encodings and FSM states for the LSU and data RAM
package mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DATA_DEPTH = 1024;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_DATA,
        ST_WR,
        RMW_RD,
        RMW_WR,
        RESP,
        ERR
    } state_t;

    // Illegal size, or an access that straddles its natural alignment.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// rtl/lsu_mem_access_if.sv - pipeline-side request/response bundle of the load/store unit
// Ports (signals):
//   req_valid/req_ready  request handshake, accepted when both high
//   req_we               1=store, 0=load
//   req_size             00=byte, 01=half, 10=word, 11=illegal
//   req_unsigned         zero-extend sub-word loads
//   req_addr             byte address
//   req_wdata            right-justified store data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata            extended load data (0 for stores/errors)
//   rsp_err              misaligned or illegal-size request
interface lsu_mem_access_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension for loads and lane merge for sub-word stores
// Ports:
//   word         RAM word (read data)
//   lane         byte address bits [1:0]
//   size         access size encoding
//   is_unsigned  zero-extend instead of sign-extend
//   wdata        right-justified store data
//   load_data    extended load result
//   store_word   word with the addressed lane(s) replaced by wdata
module lsu_align
    import mem_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            lane,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        byte_sel   = word[{lane, 3'b000} +: 8];
        half_sel   = word[{lane[1], 4'b0000} +: 16];
        byte_sign  = !is_unsigned && byte_sel[7];
        half_sign  = !is_unsigned && half_sel[15];
        load_data  = word;
        store_word = wdata;
        case (size)
            SZ_B: begin
                load_data  = {{(DATA_WIDTH-8){byte_sign}}, byte_sel};
                store_word = word;
                store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data  = {{(DATA_WIDTH-16){half_sign}}, half_sel};
                store_word = word;
                store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - byte-addressed RV32I load/store unit in front of a word-wide single-port RAM
// Ports:
//   clk, rst   clock (rising edge), synchronous active-high reset
//   bus        request/response bundle (slave side)
//   ram_addr   RAM word index (byte address bits [clog2(DATA_DEPTH)+1:2])
//   ram_din    RAM write data
//   ram_en     RAM enable, never high while rst=1
//   ram_we     RAM write enable, never high while rst=1
//   ram_dout   RAM registered read data (one-cycle latency)
module lsu_mem_access #(
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int DATA_DEPTH = mem_pkg::DATA_DEPTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    lsu_mem_access_if.slave               bus,
    output logic [$clog2(DATA_DEPTH)-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    output logic                          ram_en,
    output logic                          ram_we,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);
    import mem_pkg::*;

    localparam int RAM_AW = $clog2(DATA_DEPTH);

    state_t state_q, state_d;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [RAM_AW+1:0]     addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  accept;
    logic                  bad_req;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    // Address bits above the RAM range are deliberately dropped (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[ADDR_WIDTH-1:0];

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bad_req       = req_is_bad(bus.req_size, bus.req_addr[1:0]);

    lsu_align u_align (
        .word        (ram_dout),
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_req)                  state_d = ERR;
                    else if (!bus.req_we)         state_d = LD_RD;
                    else if (bus.req_size == SZ_W) state_d = ST_WR;
                    else                          state_d = RMW_RD;
                end
            end
            LD_RD:   state_d = LD_DATA;
            LD_DATA: state_d = RESP;
            ST_WR:   state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr[RAM_AW+1:0];
                wdata_q <= bus.req_wdata;
            end
            // Error responses appear the cycle after acceptance, so their
            // response registers load at the acceptance edge.
            if (accept && bad_req) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
            end
            // Good responses load on the edge into RESP; for loads that is the
            // edge at which ram_dout is valid (leaving LD_DATA).
            if (state_d == RESP) begin
                rsp_rdata_q <= we_q ? '0 : load_data;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        ram_en = 1'b0;
        ram_we = 1'b0;
        case (state_q)
            LD_RD, RMW_RD: ram_en = 1'b1;
            ST_WR, RMW_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            default: begin
                ram_en = 1'b0;
                ram_we = 1'b0;
            end
        endcase
        // A reset landing on RMW_WR must drop the write, not race it.
        if (rst) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    assign ram_addr = addr_q[RAM_AW+1:2];
    assign ram_din  = (state_q == RMW_WR) ? store_word : wdata_q;

    assign bus.rsp_valid = ((state_q == RESP) || (state_q == ERR)) && !rst;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - scoreboard bench for lsu_mem_access with a behavioural one-cycle RAM
module tb_lsu_mem_access;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_dout;

    lsu_mem_access_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    lsu_mem_access #(.DATA_WIDTH(32), .DATA_DEPTH(1024), .ADDR_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    logic [9:0] last_we_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            last_we_addr = ram_addr;
        end
        if (ram_en) en_cnt++;
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_rdata"}, bus.rsp_rdata, mon_e.rdata);
                check({mon_e.tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
                check({mon_e.tag, "_lat"}, 32'(cyc - mon_e.t), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 20);
        if (!bus.req_ready) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = lat;
            e.t     = cyc;
            e.tag   = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    int we0;
    int en0;
    logic [31:0] mem4_before;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        ram_dout         = 32'd0;
        rst              = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_wdata    = 32'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
            check("rst_en", {31'd0, ram_en}, 32'd0);
            check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            check("rst_rdata", bus.rsp_rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        we0 = we_cnt;
        issue("sw", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("sw_we_count", 32'(we_cnt - we0), 32'd1);
        check("sw_we_addr", {22'd0, last_we_addr}, 32'd4);
        check("sw_mem", mem[4], 32'hDEADBEEF);

        issue("lw", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        issue("sb", 1'b1, SZ_B, 1'b0, 32'h11, 32'h80, 32'h0, 1'b0, 3);
        check("sb_mem", mem[4], 32'hDEAD80EF);
        issue("lb", 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        issue("lbu", 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0, 3);

        issue("sh", 1'b1, SZ_H, 1'b0, 32'h12, 32'h1234, 32'h0, 1'b0, 3);
        check("sh_mem", mem[4], 32'h123480EF);
        issue("lh_hi", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0, 3);
        issue("lh_lo", 1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFF80EF, 1'b0, 3);
        issue("lhu_lo", 1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h000080EF, 1'b0, 3);

        en0 = en_cnt;
        mem4_before = mem[4];
        issue("err_lw13", 1'b0, SZ_W, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
        issue("err_sh11", 1'b1, SZ_H, 1'b0, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1);
        issue("err_sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        check("err_no_ram_en", 32'(en_cnt - en0), 32'd0);
        check("err_mem_unchanged", mem[4], mem4_before);

        issue("lw_wrap", 1'b0, SZ_W, 1'b0, 32'h1010, 32'h0, 32'h123480EF, 1'b0, 3);

        we0 = we_cnt;
        @(posedge clk);
        #1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_B;
        bus.req_addr  = 32'h11;
        bus.req_wdata = 32'h55;
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("abort_accept", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_we_gated", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", {31'd0, bus.req_ready}, 32'd1);
        check("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        check("abort_no_write", 32'(we_cnt - we0), 32'd0);
        issue("lw_after_abort", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h123480EF, 1'b0, 3);

        issue("sb_lane3", 1'b1, SZ_B, 1'b0, 32'h13, 32'h000001AB, 32'h0, 1'b0, 3);
        check("sb_lane3_mem", mem[4], 32'hAB3480EF);
        issue("lb_lane3", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFFAB, 1'b0, 3);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store access unit sitting directly upstream of the single-port data RAM.
- The RAM is word-wide, word-addressed, has no byte enables and one-cycle registered read latency.
- This block takes byte-addressed RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests from the pipeline and drives the RAM's addr/din/en/we.
- It performs read-modify-write for sub-word stores and lane extraction plus sign/zero extension for loads, returning one response per request.

Parameters:
DATA_WIDTH, 32, RAM word width in bits (fixed at 32 for RV32I)
DATA_DEPTH, 1024, RAM depth in words; RAM index width = clog2(DATA_DEPTH)
ADDR_WIDTH, 32, request byte-address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and LW
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified
rsp_valid  out  1  one-cycle pulse: load data / store done / error
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-size request, qualified by rsp_valid
ram_addr  out  clog2(DATA_DEPTH)  RAM word index = addr[clog2(DATA_DEPTH)+1:2]
ram_din  out  DATA_WIDTH  RAM write data
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_dout  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset: state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, latched request regs=0; ram_en and ram_we are gated with !rst, so no RAM access occurs in any cycle where rst=1.
- req_ready = (state==IDLE) && !rst. On acceptance (cycle T), latch we/size/unsigned/addr/wdata.
- Byte address bits above clog2(DATA_DEPTH)+1 are ignored; access wraps modulo 4*DATA_DEPTH.
- Little-endian lanes:
  - lane = addr[1:0]
  - byte uses bits [8*lane+7 : 8*lane]
  - half uses bits [16*addr[1]+15 : 16*addr[1]]
- Error check at acceptance: size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> state ERR. No RAM access. rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle T+1.
- States: IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP, ERR.
- Load: IDLE -> LD_RD (T+1: ram_en=1, ram_we=0) -> LD_DATA (T+2: ram_dout valid; extract/extend and register into rsp_rdata) -> RESP (T+3: rsp_valid=1) -> IDLE.
- Word store: IDLE -> ST_WR (T+1: ram_en=1, ram_we=1, ram_din=wdata) -> RESP (T+2) -> IDLE.
- Byte/half store: IDLE -> RMW_RD (T+1: read) -> RMW_WR (T+2: ram_en=1, ram_we=1, ram_din = ram_dout with selected lane(s) replaced by wdata[7:0] or wdata[15:0]) -> RESP (T+3) -> IDLE.
- In all states other than LD_RD/ST_WR/RMW_RD/RMW_WR: ram_en=0 and ram_we=0. ram_addr and ram_din are don't-care when ram_en=0; drive them from latched regs anyway.
- rsp_valid is a single-cycle pulse. rsp_rdata and rsp_err hold until the next response.
- Next request is accepted at earliest the cycle after RESP/ERR (back-to-back throughput: 1 access per 3-4 cycles).
- Reset mid-operation: aborts at the next edge, no response is issued, any pending RMW write is dropped, and RAM contents stay unchanged (gating above guarantees this).
- req_valid deasserted while idle: nothing happens. Request inputs are ignored when req_ready=0.

Decomposition:
- Shared package mem_pkg:
  - size encodings (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10)
  - FSM state enum
  - DATA_WIDTH/DATA_DEPTH constants, shared with the RAM
- One combinational sub-module, lsu_align:
  - inputs: word, lane, size, unsigned, wdata
  - outputs: extended load data and merged store word
- FSM, request latch and response registers stay in lsu_mem_access.

Test Plan:
- Reset held 3 cycles with req_valid=1 -> req_ready=0, ram_en=0, rsp_valid=0, rsp_rdata=0 throughout; req_ready=1 the cycle after release.
- SW 0xDEADBEEF @0x10 then LW @0x10 -> ram_we=1 once at ram_addr=4; LW returns rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly at T+3.
- SB wdata=0x80 @0x11 over 0xDEADBEEF -> RAM word 4 = 0xDEAD80EF, rsp_valid at T+3. LB @0x11 -> 0xFFFFFF80. LBU @0x11 -> 0x00000080.
- SH 0x1234 @0x12 -> word 0x123480EF. LH @0x12 -> 0x00001234. LH @0x10 -> 0xFFFF80EF. LHU @0x10 -> 0x000080EF.
- LW @0x13, SH @0x11, size=11 @0x10 -> each gives rsp_valid+rsp_err at T+1, rsp_rdata=0, ram_en never asserted, memory unchanged.
- SB @0x11 with rst asserted during the RMW_WR cycle -> ram_we never 1, no rsp_valid, state IDLE after the edge; subsequent LW @0x10 returns the pre-store value.
